// File: rtl/uart_tx_fifo_path.sv
// rtl/uart_tx_fifo_path.sv - byte FIFO drained by an 8N1 UART transmitter
module uart_tx_fifo_path #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              TX_wr,
  input  logic [7:0]        TX_wdata,
  output logic              TX_full,
  output logic              TX_empty,
  output logic [ADDR_W:0]   TX_count,
  output logic              TX_ovf,
  output logic              tx,
  output logic              tx_busy
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        sh_q, sh_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        mem_q [DEPTH];

  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              push;
  logic              baud_done;
  logic [2:0]        idx_nxt;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == (ADDR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  // Full is judged on registered pointers, so a same-cycle pop never frees a slot.
  assign push      = TX_wr & ~full;
  assign baud_done = (cnt_q == CNT_W'(DIV - 1));
  assign idx_nxt   = idx_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    ovf_d    = TX_wr & full;

    if (push) begin
      wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!empty) begin
          sh_d     = mem_q[rd_ptr_q[ADDR_W-1:0]];
          rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_done) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_nxt;
            tx_d  = sh_q[idx_nxt];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= TX_wdata;
    end
  end

  assign TX_full  = full;
  assign TX_empty = empty;
  assign TX_count = count;
  assign TX_ovf   = ovf_q;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_path.sv
// tb/tb_uart_tx_fifo_path.sv - scoreboard bench for uart_tx_fifo_path
module tb_uart_tx_fifo_path;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            TX_wr = 1'b0;
  logic [7:0]      TX_wdata = 8'h00;
  logic            TX_full;
  logic            TX_empty;
  logic [ADDR_W:0] TX_count;
  logic            TX_ovf;
  logic            tx;
  logic            tx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents, line schedule, scoreboard of bytes owed to the line.
  logic [7:0] fifo_m [$];
  logic [7:0] exp_q  [$];
  int         cyc      = 0;
  int         next_ok  = 0;
  int         last_pop = -1;
  logic [7:0] cur_b    = 8'h00;
  logic       exp_ovf  = 1'b0;

  uart_tx_fifo_path #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .TX_wr   (TX_wr),
    .TX_wdata(TX_wdata),
    .TX_full (TX_full),
    .TX_empty(TX_empty),
    .TX_count(TX_count),
    .TX_ovf  (TX_ovf),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic model_busy();
    return (last_pop >= 0) && ((cyc - last_pop) < FRAME);
  endfunction

  task automatic check_outputs();
    int   k;
    logic et;
    k = cyc - last_pop;
    if (!model_busy())        et = 1'b1;
    else if (k < DIV)         et = 1'b0;
    else if (k < 9 * DIV)     et = cur_b[k / DIV - 1];
    else                      et = 1'b1;
    chk("tx_count", TX_count, fifo_m.size());
    chk("tx_full",  TX_full,  fifo_m.size() == DEPTH);
    chk("tx_empty", TX_empty, fifo_m.size() == 0);
    chk("tx_ovf",   TX_ovf,   exp_ovf);
    chk("tx_busy",  tx_busy,  model_busy());
    chk("tx_line",  tx,       et);
  endtask

  task automatic step(input logic wr, input logic [7:0] d);
    logic full_pre;
    logic pop;
    TX_wr    = wr;
    TX_wdata = d;
    @(posedge clk);
    cyc++;
    full_pre = (fifo_m.size() == DEPTH);
    pop      = (fifo_m.size() > 0) && (cyc >= next_ok);
    if (pop) begin
      cur_b    = fifo_m.pop_front();
      last_pop = cyc;
      next_ok  = cyc + FRAME + 1;
    end
    if (wr && !full_pre) begin
      fifo_m.push_back(d);
      exp_q.push_back(d);
    end
    exp_ovf = wr && full_pre;
    #1;
    TX_wr = 1'b0;
    check_outputs();
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 5000 && (fifo_m.size() > 0 || model_busy()); i++) step(1'b0, 8'h00);
    chk("drain_timeout", (fifo_m.size() > 0 || model_busy()), 0);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
  endtask

  task automatic wait_until_pop_edge();
    for (int i = 0; i < 2 * FRAME && (cyc + 1 < next_ok); i++) step(1'b0, 8'h00);
  endtask

  task automatic wait_neg(input int n, inout bit ab);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Line monitor: decodes each 8N1 frame mid-bit and checks it against the scoreboard.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] expb;
    bit         ab;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        ab  = 1'b0;
        got = 8'h00;
        wait_neg(DIV / 2, ab);
        if (!ab) chk("mon_start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          if (!ab) begin
            wait_neg(DIV, ab);
            got[i] = tx;
          end
        end
        if (!ab) wait_neg(DIV, ab);
        if (!ab) begin
          chk("mon_stop_bit", tx, 1);
          chk("mon_queue_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            expb = exp_q.pop_front();
            chk("mon_byte", got, expb);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",    tx,       1);
    chk("rst_busy",  tx_busy,  0);
    chk("rst_count", TX_count, 0);
    chk("rst_empty", TX_empty, 1);
    chk("rst_full",  TX_full,  0);
    chk("rst_ovf",   TX_ovf,   0);
    rst = 1'b0;

    // Single byte
    step(1'b1, 8'hA5);
    drain();

    // Reset during data bit 3
    step(1'b1, 8'($urandom));
    for (int i = 0; i < 200 && !(last_pop >= 0 && cyc - last_pop == 43); i++) step(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx",    tx,       1);
    chk("midrst_busy",  tx_busy,  0);
    chk("midrst_count", TX_count, 0);
    chk("midrst_empty", TX_empty, 1);
    fifo_m.delete();
    exp_q.delete();
    last_pop = -1;
    next_ok  = 0;
    exp_ovf  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) step(1'b0, 8'h00);

    // Fill and overflow, first byte arriving as the held frame ends
    step(1'b1, 8'h77);
    step(1'b0, 8'h00);
    for (int i = 0; i < 2 * FRAME && (cyc + 1 < next_ok - 1); i++) step(1'b0, 8'h00);
    for (int b = 1; b <= 6; b++) step(1'b1, 8'(b));

    // Full plus same-edge pop: push dropped; then count 2 with push+pop
    wait_until_pop_edge();
    step(1'b1, 8'h99);
    wait_until_pop_edge();
    step(1'b0, 8'h00);
    wait_until_pop_edge();
    step(1'b1, 8'h3C);
    drain();

    // Back-to-back frames
    step(1'b1, 8'h55);
    step(1'b1, 8'hFF);
    drain();

    // Pointer wrap
    n = 0;
    for (int i = 0; i < 3000 && n < 9; i++) begin
      if (fifo_m.size() < DEPTH) begin
        step(1'b1, 8'(8'h10 + n));
        n++;
      end else begin
        step(1'b0, 8'h00);
      end
    end
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) step(1'b1, 8'($urandom));
      else                            step(1'b0, 8'h00);
    end
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_path.md
Name: uart_tx_fifo_path

Overview:
- Transmit half of the UART subsystem, directly downstream of the APB FIFO slave interface.
- Accepts single-cycle byte write strobes into a synchronous FIFO and reports full/empty/count back to the interface.
- Drains the FIFO autonomously through an 8N1 UART transmitter onto the PC-facing tx line.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, ≥2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- CLK_HZ, 100_000_000, clk frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DIV is derived as CLK_HZ/BAUD, integer division. It is the number of clk cycles per bit and must be ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- TX_wr  in  1  push strobe; one byte per high cycle.
- TX_wdata  in  8  byte to push; sampled when TX_wr=1.
- TX_full  out  1  FIFO holds DEPTH entries.
- TX_empty  out  1  FIFO holds 0 entries.
- TX_count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- TX_ovf  out  1  one-cycle pulse when a push is dropped because the FIFO is full.
- tx  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is on the line (START through STOP).

Behaviour:
- Reset (asynchronous, immediate):
  - Pointers and count cleared: TX_count=0, TX_empty=1, TX_full=0.
  - TX_ovf=0, tx=1, tx_busy=0.
  - FSM forced to IDLE; baud counter and bit index cleared.
  - FIFO contents need not be cleared.
  - Reset asserted mid-frame aborts the frame; tx returns high at once.
- FIFO storage:
  - Registered memory with wr_ptr and rd_ptr, each ADDR_W+1 bits, wrapping modulo 2*DEPTH.
  - count = wr_ptr - rd_ptr.
  - TX_full = (count==DEPTH); TX_empty = (count==0). Both are combinational from registered pointers.
- Push:
  - Push happens at the clk edge when TX_wr=1 and TX_full=0.
  - TX_count/flags reflect the push from the next cycle.
  - If TX_wr=1 while TX_full=1, the byte is dropped, pointers are unchanged, and TX_ovf=1 for exactly the next cycle.
  - A simultaneous pop does NOT make room for a push in that same cycle.
- Pop:
  - Pop is internal only: it occurs in IDLE when TX_empty=0.
  - The head byte is loaded into shift register sh[7:0] and rd_ptr increments at that edge.
  - Push and pop in the same cycle are both applied; count is unchanged.
  - A push into an empty FIFO cannot be popped in the same cycle; the earliest pop is the following cycle.
- FSM states:
  - IDLE: tx=1, busy=0. If !TX_empty, pop, then go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit index=0.
  - DATA: tx=sh[idx], LSB first, DIV cycles per bit. idx increments 0..7; after bit 7 completes, go to STOP.
  - STOP: tx=1 for DIV cycles, then go to IDLE.
- Baud timing:
  - Baud counter runs 0..DIV-1 only outside IDLE and resets to 0 on every state entry, so there is no drift between frames.
  - tx is driven from a register, glitch-free.
- Latency and throughput:
  - Push at edge N → pop at edge N+1 → tx falls at edge N+1 (START registered).
  - Frame length is exactly 10*DIV cycles.
  - Back-to-back frames have one IDLE cycle between STOP end and the next START, so the gap is 10*DIV+1 cycles per byte.
- tx_busy is high in START, DATA and STOP.
- Pushes are accepted in all FSM states.

Test Plan:
- Test configuration: CLK_HZ=1000, BAUD=100 (DIV=10), DEPTH=4.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1, tx_busy=0, TX_count=0, TX_empty=1 in the same cycle. After release, no frame starts until a new push.
- Single byte: push 8'hA5 at edge 0 → TX_count=1 after edge 0, 0 after edge 1. tx low for cycles 1–10, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles. tx_busy high for exactly 100 cycles.
- Fill and overflow while idle-blocked: hold a frame in progress, then push 5 bytes 8'h01..8'h05 on consecutive cycles. Required response:
  - The first byte is popped on the next cycle.
  - TX_full=1 after 8'h05 is stored.
  - A 6th push 8'h06 gives TX_ovf=1 for one cycle and TX_count stays 4.
  - Line output order is 01,02,03,04,05.
- Simultaneous push/pop: with count=4 (full), push at the same edge the FSM pops → push dropped, TX_ovf pulses, count becomes 3. With count=2 and a same-edge push+pop → count stays 2.
- Back-to-back: push 8'h55, 8'hFF → two frames. The second START falls exactly 101 cycles after the first, with one high IDLE cycle between the stop bit and the second start.
- Pointer wrap: push/drain 9 bytes in sequence 8'h10..8'h18 → all transmitted in order with correct values. TX_empty=1 and TX_count=0 at the end.
